// File: rtl/alu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_sequencer
//  Brief    : Multicycle decode/execute/writeback sequencer for the i281 ALU
//             datapath with a retired-instruction counter.
//  Options  : ALU_SEQ_FLAGS_EN - enables flags_we and makes CMP (opcode 6) legal.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int OPC_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_start,
    input  logic [OPC_W-1:0] i_opcode,
    output logic [2:0]       o_alu_op,
    output logic             o_srcb_sel,
    output logic             o_c22,
    output logic             o_flags_we,
    output logic             o_reg_we,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam logic [OPC_W-1:0] c_OP_ADD    = OPC_W'(0);
    localparam logic [OPC_W-1:0] c_OP_ADDI   = OPC_W'(1);
    localparam logic [OPC_W-1:0] c_OP_SUB    = OPC_W'(2);
    localparam logic [OPC_W-1:0] c_OP_SUBI   = OPC_W'(3);
    localparam logic [OPC_W-1:0] c_OP_SHIFTL = OPC_W'(4);
    localparam logic [OPC_W-1:0] c_OP_SHIFTR = OPC_W'(5);
    localparam logic [OPC_W-1:0] c_OP_CMP    = OPC_W'(6);

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_SHL = 3'b010;
    localparam logic [2:0] c_ALU_SHR = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_DONE      = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [OPC_W-1:0]   r_opcode;
    logic [CNT_W-1:0]   r_count;

    logic               w_is_cmp;
    logic               w_legal;
    logic               w_flags_en;
    logic               w_enter_done;
    logic               w_c22;
    logic               w_flags_we;
    logic               w_reg_we;
    logic               w_done;
    logic               w_err;
    logic [2:0]         w_alu_op;
    logic               w_srcb_sel;

    assign w_is_cmp = (r_opcode == c_OP_CMP);

`ifdef ALU_SEQ_FLAGS_EN
    assign w_flags_en = 1'b1;
    assign w_legal    = (r_opcode <= c_OP_CMP);
`else
    assign w_flags_en = 1'b0;
    assign w_legal    = (r_opcode < c_OP_CMP);
`endif

    // Datapath selects decode straight from the latched opcode, so they
    // naturally hold through DONE/FAULT/IDLE until the next accept.
    always_comb begin
        w_alu_op   = c_ALU_ADD;
        w_srcb_sel = 1'b0;
        case (r_opcode)
            c_OP_ADD:    w_alu_op = c_ALU_ADD;
            c_OP_ADDI: begin
                w_alu_op   = c_ALU_ADD;
                w_srcb_sel = 1'b1;
            end
            c_OP_SUB:    w_alu_op = c_ALU_SUB;
            c_OP_SUBI: begin
                w_alu_op   = c_ALU_SUB;
                w_srcb_sel = 1'b1;
            end
            c_OP_SHIFTL: w_alu_op = c_ALU_SHL;
            c_OP_SHIFTR: w_alu_op = c_ALU_SHR;
            c_OP_CMP:    w_alu_op = c_ALU_SUB;
            default:     w_alu_op = c_ALU_ADD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (i_run) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_c22      = 1'b0;
        w_flags_we = 1'b0;
        w_reg_we   = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_legal ? S_EXECUTE : S_FAULT;
            end
            S_EXECUTE: begin
                w_c22      = ~w_is_cmp;
                w_flags_we = w_flags_en;
                w_next     = w_is_cmp ? S_DONE : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                w_reg_we = 1'b1;
                w_next   = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            S_FAULT: begin
                w_err  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_opcode <= '0;
        end else if (i_run && (r_state == S_IDLE) && i_start) begin
            r_opcode <= i_opcode;
        end
    end

    assign w_enter_done = i_run && (w_next == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_enter_done) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Strobes are suppressed while frozen; selects and busy stay state-decoded.
    assign o_c22         = w_c22      & i_run;
    assign o_flags_we    = w_flags_we & i_run;
    assign o_reg_we      = w_reg_we   & i_run;
    assign o_done        = w_done     & i_run;
    assign o_err         = w_err      & i_run;
    assign o_alu_op      = w_alu_op;
    assign o_srcb_sel    = w_srcb_sel;
    assign o_busy        = (r_state != S_IDLE);
    assign o_instr_count = r_count;

endmodule
`default_nettype wire
